icb_arb_2m1s: RTL and testbench
===============================

Name: icb_arb_2m1s

Overview:
- Two-master to one-slave ICB arbiter. It shares a single downstream ICB port (normally the master side of the 8-slave bus decoder) between m0 (debug) and m1 (core).
- m0 has fixed priority. A starvation counter guarantees m1 progress.
- Every accepted command gets exactly one response. An in-order ID FIFO tracks which master owns each outstanding command, so responses route correctly and are never lost.
- The slave is in-order, so grants may switch between masters while responses are still outstanding.

Parameters:
AW, 32, address width
DW, 32, data width
OUTS_DEPTH, 4, max outstanding commands (power of 2, >=2)
STARVE_MAX, 15, cycles m1 may wait while m0 holds the bus before m1 is forced a grant

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock, asynchronous, active-low
m0_icb_cmd_valid/ready  in/out  1  m0 command handshake
m0_icb_cmd_addr  in  AW  m0 address
m0_icb_cmd_read  in  1  m0 read=1 / write=0
m0_icb_cmd_wdata  in  DW  m0 write data
m0_icb_cmd_wmask  in  DW/8  m0 byte enables
m0_icb_rsp_valid/ready  out/in  1  m0 response handshake
m0_icb_rsp_err  out  1  m0 response error
m0_icb_rsp_rdata  out  DW  m0 read data
m1_icb_*  (same set as m0)  core master
s_icb_cmd_valid/ready  out/in  1  downstream command handshake
s_icb_cmd_addr/read/wdata/wmask  out  AW/1/DW/DW/8  muxed command payload
s_icb_rsp_valid/ready  in/out  1  downstream response handshake
s_icb_rsp_err  in  1  downstream error
s_icb_rsp_rdata  in  DW  downstream read data
outstanding  out  $clog2(OUTS_DEPTH+1)  FIFO occupancy
rsp_orphan  out  1  sticky: s_icb_rsp_valid seen while FIFO empty

Behaviour:
- Reset (async, rst_n=0) sets: lock=0, gnt=1 (m1), FIFO empty, outstanding=0, starve_cnt=0, rsp_orphan=0. While in reset, all *_valid/*_ready outputs must be 0.
- Arbitration is combinational when lock=0. The winner is evaluated in this order:
  - both valid and starve_cnt==STARVE_MAX -> m1
  - both valid otherwise -> m0
  - only one valid -> that master
  - none valid -> gnt holds
- Registered gnt is updated each cycle to the winner.
- lock sets at a clock edge where s_icb_cmd_valid=1 and s_icb_cmd_ready=0. While lock=1, the winner is the registered gnt, so the ICB payload stays stable.
- lock clears on the granted master's handshake, or if the granted master drops valid (protocol violation: no grant change that cycle, arbitrate next cycle).
- Command path:
  - s_icb_cmd_valid = granted master's valid & ~full.
  - Payload is muxed by the winner.
  - mX_icb_cmd_ready = (winner==X) & s_icb_cmd_ready & ~full.
  - The non-winner's ready is 0.
- A command handshake pushes the winner ID (1 bit) into the FIFO. This applies to reads and writes alike; each produces one response.
- full blocks a push even if a pop happens in the same cycle. Push and pop in the same cycle when not full leaves occupancy unchanged.
- Response path:
  - head = FIFO front ID.
  - mX_icb_rsp_valid = (head==X) & s_icb_rsp_valid & ~empty.
  - s_icb_rsp_ready = mhead_icb_rsp_ready & ~empty.
  - rsp_err is gated the same way as rsp_valid.
  - rdata goes to both masters unmasked.
  - A response handshake pops the FIFO. Response latency through the block is 0 cycles (combinational).
- Empty FIFO with s_icb_rsp_valid=1: s_icb_rsp_ready=0, no mX_icb_rsp_valid, rsp_orphan sets and stays set until reset.
- starve_cnt:
  - increments (saturating at STARVE_MAX) each cycle m1_icb_cmd_valid=1 and m1 does not handshake;
  - clears on an m1 handshake or when m1_icb_cmd_valid=0.
- Reset asserted mid-transaction drops all state immediately. Responses pending downstream become orphans after reset.
- outstanding equals FIFO occupancy, registered.

Test Plan:
- Only m1 issues 4 back-to-back reads (OUTS_DEPTH=4) with the slave rsp withheld -> 4 handshakes, outstanding=4, 5th command sees m1_icb_cmd_ready=0. One response pops -> the 5th is accepted in the next cycle.
- m0 and m1 both valid in the same cycle with the slave always ready -> m0 granted. m0 held valid continuously -> m1 granted on cycle 16 (STARVE_MAX=15), then m0 again.
- m1 wins and the slave holds ready=0 for 3 cycles while m0 asserts valid -> s_icb_cmd_addr equals m1's address all 4 cycles, m0_icb_cmd_ready=0, m1 handshakes on cycle 4.
- Interleave m0 write (ID0), m1 read (ID1), m0 read (ID0); slave returns 3 in-order responses with rdata 0xA5A5A5A5 on the 2nd -> m0 rsp, then m1 rsp with 0xA5A5A5A5, then m0 rsp. m1_icb_rsp_ready=0 for 2 cycles stalls s_icb_rsp_ready.
- Slave drives s_icb_rsp_valid with the FIFO empty -> no master rsp_valid, rsp_orphan=1 until rst_n pulses low.
- Assert rst_n=0 asynchronously with outstanding=2 and lock=1 -> outstanding=0, lock=0, outputs 0 without waiting for a clk edge.

Source files
------------

// File: rtl/icb_arb_2m1s_if.sv
// ICB port bundle: command channel plus in-order response channel.
// master drives commands, slave drives ready and responses.
interface icb_arb_2m1s_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [AW-1:0]   cmd_addr;
    logic            cmd_read;
    logic [DW-1:0]   cmd_wdata;
    logic [DW/8-1:0] cmd_wmask;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_err;
    logic [DW-1:0]   rsp_rdata;

    modport master (
        output cmd_valid, cmd_addr, cmd_read,
        output cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_read,
        input  cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/icb_arb_2m1s.sv
// Two-master to one-slave ICB arbiter: m0 fixed priority, m1 anti-starvation,
// in-order ID FIFO routes each response back to its issuing master.
module icb_arb_2m1s #(
    parameter  int AW         = 32,
    parameter  int DW         = 32,
    parameter  int OUTS_DEPTH = 4,
    parameter  int STARVE_MAX = 15,
    localparam int PW         = $clog2(OUTS_DEPTH),
    localparam int CW         = $clog2(OUTS_DEPTH + 1),
    localparam int SW         = $clog2(STARVE_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    icb_arb_2m1s_if.slave        m0_icb,
    icb_arb_2m1s_if.slave        m1_icb,
    icb_arb_2m1s_if.master       s_icb,
    output logic [CW-1:0]        outstanding,
    output logic                 rsp_orphan
);

    typedef enum logic {
        ST_ARB,
        ST_LOCK
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_gnt;
    logic            w_win;
    logic            w_gv;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_head;
    logic            w_rv;
    logic            w_m1_hs;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_wp;
    logic [PW-1:0]   r_rp;
    logic [OUTS_DEPTH-1:0] r_ids;
    logic [SW-1:0]   r_starve;
    logic            r_orphan;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_wdata;
    logic [DW/8-1:0] w_wmask;

    assign w_full  = (r_cnt == CW'(OUTS_DEPTH));
    assign w_empty = (r_cnt == '0);

    // While locked the registered grant wins so the payload stays put.
    always_comb begin
        w_win = r_gnt;
        if (r_state == ST_LOCK) begin
            w_win = r_gnt;
        end else if (m0_icb.cmd_valid && m1_icb.cmd_valid) begin
            w_win = (r_starve == SW'(STARVE_MAX));
        end else if (m0_icb.cmd_valid) begin
            w_win = 1'b0;
        end else if (m1_icb.cmd_valid) begin
            w_win = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = ST_ARB;
        if (s_icb.cmd_valid && !s_icb.cmd_ready) begin
            w_state_nxt = ST_LOCK;
        end
    end

    always_comb begin
        w_addr  = m0_icb.cmd_addr;
        w_wdata = m0_icb.cmd_wdata;
        w_wmask = m0_icb.cmd_wmask;
        if (w_win) begin
            w_addr  = m1_icb.cmd_addr;
            w_wdata = m1_icb.cmd_wdata;
            w_wmask = m1_icb.cmd_wmask;
        end
    end

    assign w_gv = w_win ? m1_icb.cmd_valid : m0_icb.cmd_valid;

    assign s_icb.cmd_valid = w_gv & ~w_full & rst_n;
    assign s_icb.cmd_addr  = w_addr;
    assign s_icb.cmd_wdata = w_wdata;
    assign s_icb.cmd_wmask = w_wmask;
    assign s_icb.cmd_read  = w_win ? m1_icb.cmd_read
                                   : m0_icb.cmd_read;

    assign m0_icb.cmd_ready = ~w_win & s_icb.cmd_ready & ~w_full & rst_n;
    assign m1_icb.cmd_ready =  w_win & s_icb.cmd_ready & ~w_full & rst_n;

    assign w_push  = s_icb.cmd_valid & s_icb.cmd_ready;
    assign w_m1_hs = m1_icb.cmd_valid & m1_icb.cmd_ready;

    assign w_head = r_ids[r_rp];
    assign w_rv   = s_icb.rsp_valid & ~w_empty & rst_n;

    assign m0_icb.rsp_valid = w_rv & ~w_head;
    assign m1_icb.rsp_valid = w_rv &  w_head;
    assign m0_icb.rsp_err   = s_icb.rsp_err & w_rv & ~w_head;
    assign m1_icb.rsp_err   = s_icb.rsp_err & w_rv &  w_head;
    assign m0_icb.rsp_rdata = s_icb.rsp_rdata;
    assign m1_icb.rsp_rdata = s_icb.rsp_rdata;

    assign s_icb.rsp_ready = (w_head ? m1_icb.rsp_ready : m0_icb.rsp_ready)
                           & ~w_empty & rst_n;
    assign w_pop = s_icb.rsp_valid & s_icb.rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ARB;
            r_gnt   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ids <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_ids[r_wp] <= w_win;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (m1_icb.cmd_valid && !w_m1_hs) begin
            if (r_starve != SW'(STARVE_MAX)) begin
                r_starve <= r_starve + 1'b1;
            end
        end else begin
            r_starve <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_orphan <= 1'b0;
        end else if (s_icb.rsp_valid && w_empty) begin
            r_orphan <= 1'b1;
        end
    end

    assign outstanding = r_cnt;
    assign rsp_orphan  = r_orphan;

endmodule

// File: tb/tb_icb_arb_2m1s.sv
// Self-checking bench for icb_arb_2m1s: vector table for arbitration/lock,
// ID scoreboard for response routing, directed corner-case sequences.
module tb_icb_arb_2m1s;

    localparam logic [31:0] M0A = 32'h0000_0100;
    localparam logic [31:0] M1A = 32'h1000_0004;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] outstanding;
    logic       rsp_orphan;

    always #5 clk = ~clk;

    icb_arb_2m1s_if #(.AW(32), .DW(32)) m0 ();
    icb_arb_2m1s_if #(.AW(32), .DW(32)) m1 ();
    icb_arb_2m1s_if #(.AW(32), .DW(32)) s ();

    icb_arb_2m1s #(
        .AW(32), .DW(32), .OUTS_DEPTH(4), .STARVE_MAX(15)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .m0_icb(m0),
        .m1_icb(m1),
        .s_icb(s),
        .outstanding(outstanding),
        .rsp_orphan(rsp_orphan)
    );

    typedef struct {
        logic        m0v;
        logic        m1v;
        logic        sr;
        logic        m0r;
        logic        m1r;
        logic        sv;
        logic [31:0] addr;
        int          outs;
    } vec_t;

    vec_t tbl[6];
    int   n_pass = 0;
    int   n_tot  = 0;
    bit   q[$];
    bit   auto_rsp = 1'b0;

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
        if (auto_rsp) s.rsp_valid = (q.size() != 0);
    endtask

    task automatic drain();
        auto_rsp     = 1'b1;
        m0.rsp_ready = 1'b1;
        m1.rsp_ready = 1'b1;
        m0.cmd_valid = 1'b0;
        m1.cmd_valid = 1'b0;
        for (int i = 0; i < 12 && q.size() != 0; i++) nxt();
        nxt();
        #2;
        chk("drain_q_empty", q.size(), 0);
        chk("drain_outstanding", outstanding, 0);
        auto_rsp   = 1'b0;
        s.rsp_valid = 1'b0;
    endtask

    // Scoreboard: which master owns each accepted command, in order.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (s.rsp_valid && s.rsp_ready) begin
                if (q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    bit id;
                    id = q.pop_front();
                    chk("sb_m0_rsp_valid", m0.rsp_valid, !id);
                    chk("sb_m1_rsp_valid", m1.rsp_valid, id);
                end
            end
            if (m0.cmd_valid && m0.cmd_ready) q.push_back(1'b0);
            if (m1.cmd_valid && m1.cmd_ready) q.push_back(1'b1);
        end
    end

    always @(negedge rst_n) q.delete();

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, M1A, 0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, M1A, 0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, M1A, 0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, M1A, 0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, M0A, 1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, M0A, 2};

        rst_n        = 1'b0;
        m0.cmd_valid = 1'b1;
        m0.cmd_addr  = M0A;
        m0.cmd_read  = 1'b1;
        m0.cmd_wdata = '0;
        m0.cmd_wmask = '1;
        m0.rsp_ready = 1'b1;
        m1.cmd_valid = 1'b1;
        m1.cmd_addr  = M1A;
        m1.cmd_read  = 1'b1;
        m1.cmd_wdata = '0;
        m1.cmd_wmask = '1;
        m1.rsp_ready = 1'b1;
        s.cmd_ready  = 1'b1;
        s.rsp_valid  = 1'b1;
        s.rsp_err    = 1'b0;
        s.rsp_rdata  = '0;

        #12;
        chk("rst_s_cmd_valid", s.cmd_valid, 0);
        chk("rst_m0_cmd_ready", m0.cmd_ready, 0);
        chk("rst_m1_cmd_ready", m1.cmd_ready, 0);
        chk("rst_s_rsp_ready", s.rsp_ready, 0);
        chk("rst_m0_rsp_valid", m0.rsp_valid, 0);
        chk("rst_m1_rsp_valid", m1.rsp_valid, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_orphan", rsp_orphan, 0);

        @(posedge clk);
        #1;
        m0.cmd_valid = 1'b0;
        m1.cmd_valid = 1'b0;
        s.rsp_valid  = 1'b0;
        s.cmd_ready  = 1'b0;
        rst_n        = 1'b1;

        // Arbitration and lock: m1 stalled 3 cycles while m0 waits.
        for (int i = 0; i < 6; i++) begin
            nxt();
            m0.cmd_valid = tbl[i].m0v;
            m1.cmd_valid = tbl[i].m1v;
            s.cmd_ready  = tbl[i].sr;
            #2;
            chk($sformatf("vec%0d_m0_ready", i), m0.cmd_ready, tbl[i].m0r);
            chk($sformatf("vec%0d_m1_ready", i), m1.cmd_ready, tbl[i].m1r);
            chk($sformatf("vec%0d_s_valid", i), s.cmd_valid, tbl[i].sv);
            chk($sformatf("vec%0d_s_addr", i), s.cmd_addr, tbl[i].addr);
            chk($sformatf("vec%0d_outs", i), outstanding, tbl[i].outs);
        end
        drain();

        // Starvation: both valid, m1 forced in on cycle 16.
        auto_rsp = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            nxt();
            m0.cmd_valid = 1'b1;
            m1.cmd_valid = 1'b1;
            s.cmd_ready  = 1'b1;
            #2;
            chk($sformatf("starve%0d_m0_ready", k), m0.cmd_ready, k != 16);
            chk($sformatf("starve%0d_m1_ready", k), m1.cmd_ready, k == 16);
        end
        drain();

        // Outstanding limit: m1 fills the FIFO, one pop frees a slot.
        for (int k = 1; k <= 5; k++) begin
            nxt();
            m1.cmd_valid = 1'b1;
            m1.cmd_read  = 1'b1;
            s.cmd_ready  = 1'b1;
            #2;
            chk($sformatf("full%0d_m1_ready", k), m1.cmd_ready, k <= 4);
            chk($sformatf("full%0d_outs", k), outstanding, k - 1);
        end
        chk("full_s_valid", s.cmd_valid, 0);
        nxt();
        s.rsp_valid = 1'b1;
        #2;
        chk("full_pop_s_rsp_ready", s.rsp_ready, 1);
        chk("full_pop_m1_ready", m1.cmd_ready, 0);
        nxt();
        s.rsp_valid = 1'b0;
        #2;
        chk("full_after_m1_ready", m1.cmd_ready, 1);
        chk("full_after_outs", outstanding, 3);
        nxt();
        m1.cmd_valid = 1'b0;
        #2;
        chk("full_refill_outs", outstanding, 4);
        drain();

        // Interleaved owners and response backpressure.
        nxt();
        m0.cmd_valid = 1'b1;
        m0.cmd_read  = 1'b0;
        m0.cmd_wdata = 32'hDEAD_BEEF;
        s.cmd_ready  = 1'b1;
        #2;
        chk("il_m0w_ready", m0.cmd_ready, 1);
        chk("il_m0w_read", s.cmd_read, 0);
        chk("il_m0w_wdata", s.cmd_wdata, 32'hDEAD_BEEF);
        nxt();
        m0.cmd_valid = 1'b0;
        m1.cmd_valid = 1'b1;
        #2;
        chk("il_m1r_ready", m1.cmd_ready, 1);
        chk("il_m1r_read", s.cmd_read, 1);
        nxt();
        m1.cmd_valid = 1'b0;
        m0.cmd_valid = 1'b1;
        m0.cmd_read  = 1'b1;
        #2;
        chk("il_m0r_ready", m0.cmd_ready, 1);
        nxt();
        m0.cmd_valid = 1'b0;
        s.rsp_valid  = 1'b1;
        s.rsp_err    = 1'b1;
        s.rsp_rdata  = 32'h1111_1111;
        m0.rsp_ready = 1'b1;
        m1.rsp_ready = 1'b0;
        #2;
        chk("il_outs3", outstanding, 3);
        chk("il_r1_m0_valid", m0.rsp_valid, 1);
        chk("il_r1_m0_err", m0.rsp_err, 1);
        chk("il_r1_m1_err", m1.rsp_err, 0);
        nxt();
        s.rsp_err   = 1'b0;
        s.rsp_rdata = 32'hA5A5_A5A5;
        #2;
        chk("il_r2_m1_valid", m1.rsp_valid, 1);
        chk("il_r2_m0_valid", m0.rsp_valid, 0);
        chk("il_r2_m1_rdata", m1.rsp_rdata, 32'hA5A5_A5A5);
        chk("il_r2_stall1", s.rsp_ready, 0);
        nxt();
        #2;
        chk("il_r2_stall2", s.rsp_ready, 0);
        chk("il_r2_outs", outstanding, 2);
        nxt();
        m1.rsp_ready = 1'b1;
        #2;
        chk("il_r2_release", s.rsp_ready, 1);
        nxt();
        s.rsp_rdata = 32'h2222_2222;
        #2;
        chk("il_r3_m0_valid", m0.rsp_valid, 1);
        chk("il_r3_s_ready", s.rsp_ready, 1);
        nxt();
        s.rsp_valid = 1'b0;
        #2;
        chk("il_done_outs", outstanding, 0);
        chk("il_done_orphan", rsp_orphan, 0);

        // Orphan response with nothing outstanding.
        nxt();
        s.rsp_valid = 1'b1;
        #2;
        chk("orph_m0_valid", m0.rsp_valid, 0);
        chk("orph_m1_valid", m1.rsp_valid, 0);
        chk("orph_s_ready", s.rsp_ready, 0);
        nxt();
        s.rsp_valid = 1'b0;
        #2;
        chk("orph_set", rsp_orphan, 1);
        repeat (3) nxt();
        #2;
        chk("orph_sticky", rsp_orphan, 1);

        // Async reset with two outstanding and a locked grant.
        nxt();
        m0.cmd_valid = 1'b1;
        s.cmd_ready  = 1'b1;
        nxt();
        nxt();
        m0.cmd_valid = 1'b0;
        m1.cmd_valid = 1'b1;
        s.cmd_ready  = 1'b0;
        #2;
        chk("ar_pre_addr", s.cmd_addr, M1A);
        chk("ar_pre_outs", outstanding, 2);
        nxt();
        #2;
        chk("ar_locked_valid", s.cmd_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_outs", outstanding, 0);
        chk("ar_s_valid", s.cmd_valid, 0);
        chk("ar_m0_ready", m0.cmd_ready, 0);
        chk("ar_m1_ready", m1.cmd_ready, 0);
        chk("ar_orphan", rsp_orphan, 0);
        nxt();
        nxt();
        rst_n        = 1'b1;
        m0.cmd_valid = 1'b1;
        m1.cmd_valid = 1'b1;
        #2;
        chk("ar_post_addr", s.cmd_addr, M0A);
        chk("ar_post_valid", s.cmd_valid, 1);
        chk("ar_post_m0_ready", m0.cmd_ready, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
